// File: rtl/sysu_cnt_extender.sv
// Extends an asynchronous 4-bit ripple counter with a glitch-filtered sampler, an upper
// wrap counter and a frozen snapshot register read through a VALID/ACK handshake.
module sysu_cnt_extender #(
  parameter int unsigned ExtW       = 8,
  parameter int unsigned SyncStages = 2
) (
  input  logic              cp_i,
  input  logic              mr_ni,
  input  logic [3:0]        q_in_i,
  input  logic              clr_i,
  input  logic              latch_i,
  input  logic              ack_i,
  output logic [ExtW+3:0]   cnt_o,
  output logic [ExtW+3:0]   snap_o,
  output logic              valid_o,
  output logic              ovf_o,
  output logic              miss_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b01,
    StHold = 2'b10
  } state_e;

  logic [3:0]            q_sync_q [SyncStages];
  logic [SyncStages-1:0] l_sync_q;
  logic                  l_prev_q;

  logic [3:0]      nib_q, nib_d;
  logic [ExtW-1:0] ext_q, ext_d;
  logic            ovf_q, ovf_d;
  logic            miss_q, miss_d;
  logic [ExtW+3:0] snap_q, snap_d;
  state_e          state_q, state_d;

  logic [3:0] q_last;
  logic [3:0] q_next;
  logic       accept;
  logic       wrap;
  logic       latch_evt;

  always_ff @(posedge cp_i or negedge mr_ni) begin
    if (!mr_ni) begin
      for (int i = 0; i < SyncStages; i++) q_sync_q[i] <= '0;
      l_sync_q <= '0;
      l_prev_q <= 1'b0;
      nib_q    <= '0;
      ext_q    <= '0;
      ovf_q    <= 1'b0;
      miss_q   <= 1'b0;
      snap_q   <= '0;
      state_q  <= StIdle;
    end else begin
      q_sync_q[0] <= q_in_i;
      for (int i = 1; i < SyncStages; i++) q_sync_q[i] <= q_sync_q[i-1];
      l_sync_q <= {l_sync_q[SyncStages-2:0], latch_i};
      l_prev_q <= l_sync_q[SyncStages-1];
      nib_q    <= nib_d;
      ext_q    <= ext_d;
      ovf_q    <= ovf_d;
      miss_q   <= miss_d;
      snap_q   <= snap_d;
      state_q  <= state_d;
    end
  end

  // A value is accepted once the last synchronized sample and the one following it agree,
  // so a single-cycle ripple intermediate never reaches the nibble.
  assign q_last    = q_sync_q[SyncStages-1];
  assign q_next    = q_sync_q[SyncStages-2];
  assign accept    = (q_next == q_last) && (q_last != nib_q);
  assign wrap      = accept && (q_last < nib_q);
  assign latch_evt = l_sync_q[SyncStages-1] & ~l_prev_q;

  always_comb begin
    nib_d  = accept ? q_last : nib_q;
    ext_d  = ext_q;
    ovf_d  = ovf_q;
    miss_d = miss_q;
    if (wrap) begin
      if (ext_q == '1) begin
        ext_d = '0;
        ovf_d = 1'b1;
      end else begin
        ext_d = ext_q + 1'b1;
      end
    end
    if (latch_evt && (state_q == StHold)) miss_d = 1'b1;
    if (clr_i) begin
      ext_d  = '0;
      ovf_d  = 1'b0;
      miss_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    case (state_q)
      StIdle: begin
        if (latch_evt) begin
          snap_d  = {ext_q, nib_q};
          state_d = StHold;
        end
      end
      StHold: begin
        if (ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cnt_o   = {ext_q, nib_q};
  assign snap_o  = snap_q;
  assign valid_o = (state_q == StHold);
  assign ovf_o   = ovf_q;
  assign miss_o  = miss_q;

endmodule

// File: tb/tb_sysu_cnt_extender.sv
// Directed bench for sysu_cnt_extender: a default instance plus a 2-bit extension instance
// sharing the same stimulus.
module tb_sysu_cnt_extender;

  logic        clk = 1'b0;
  logic        mr_n;
  logic [3:0]  q_in;
  logic        clr, latch, ack;
  logic [11:0] cnt, snap;
  logic        valid, ovf, miss;
  logic [5:0]  cnt2, snap2;
  logic        valid2, ovf2, miss2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sysu_cnt_extender #(.ExtW(8), .SyncStages(2)) dut (
    .cp_i(clk), .mr_ni(mr_n), .q_in_i(q_in), .clr_i(clr), .latch_i(latch), .ack_i(ack),
    .cnt_o(cnt), .snap_o(snap), .valid_o(valid), .ovf_o(ovf), .miss_o(miss)
  );

  sysu_cnt_extender #(.ExtW(2), .SyncStages(2)) dut2 (
    .cp_i(clk), .mr_ni(mr_n), .q_in_i(q_in), .clr_i(clr), .latch_i(latch), .ack_i(ack),
    .cnt_o(cnt2), .snap_o(snap2), .valid_o(valid2), .ovf_o(ovf2), .miss_o(miss2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    q_in = v;
    tick(n);
  endtask

  initial begin
    mr_n = 1'b0; q_in = 4'd0; clr = 1'b0; latch = 1'b0; ack = 1'b0;
    tick(3);
    check_eq("rst_cnt", 32'(cnt), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'h0);
    mr_n = 1'b1;

    // Full nibble sweep and first wrap
    for (int v = 1; v < 16; v++) hold(4'(v), 4);
    check_eq("wrap_0f", 32'(cnt), 32'h00f);
    hold(4'd0, 4);
    check_eq("wrap_10", 32'(cnt), 32'h010);
    check_eq("wrap_ovf", 32'(ovf), 32'h0);
    check_eq("wrap_10_w2", 32'(cnt2), 32'h10);

    // Extension overflow on the narrow instance after 64 counts
    for (int r = 0; r < 3; r++) begin
      for (int v = 1; v < 16; v++) hold(4'(v), 4);
      hold(4'd0, 4);
    end
    check_eq("ovf_cnt_w2", 32'(cnt2), 32'h00);
    check_eq("ovf_flag_w2", 32'(ovf2), 32'h1);
    check_eq("ovf_cnt_w8", 32'(cnt), 32'h040);
    check_eq("ovf_flag_w8", 32'(ovf), 32'h0);
    hold(4'd3, 4);
    check_eq("ovf_sticky_w2", 32'(ovf2), 32'h1);
    check_eq("ovf_nib_w2", 32'(cnt2), 32'h03);
    clr = 1'b1; tick(1); clr = 1'b0;
    check_eq("clr_ovf_w2", 32'(ovf2), 32'h0);
    check_eq("clr_cnt_w2", 32'(cnt2), 32'h03);
    check_eq("clr_cnt_w8", 32'(cnt), 32'h003);

    // Single-cycle glitch is rejected
    hold(4'd7, 1);
    q_in = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_eq("glitch_hold", 32'(cnt), 32'h003);
    end
    // Ripple sequence: only the settled endpoints are accepted
    hold(4'd7, 4);
    check_eq("ripple_7", 32'(cnt), 32'h007);
    hold(4'd6, 1);
    check_eq("ripple_6", 32'(cnt), 32'h007);
    hold(4'd4, 1);
    check_eq("ripple_4", 32'(cnt), 32'h007);
    hold(4'd0, 1);
    check_eq("ripple_0", 32'(cnt), 32'h007);
    hold(4'd8, 4);
    check_eq("ripple_8", 32'(cnt), 32'h008);

    // Backward steps each count as a wrap: reach 0x123
    for (int i = 0; i < 17; i++) begin
      hold(4'd0, 3);
      hold(4'd8, 3);
    end
    hold(4'd0, 3);
    hold(4'd3, 4);
    check_eq("pre_snap_cnt", 32'(cnt), 32'h123);

    // Snapshot handshake
    latch = 1'b1; tick(2); latch = 1'b0;
    for (int i = 0; i < 10 && !valid; i++) tick(1);
    check_eq("snap_valid", 32'(valid), 32'h1);
    check_eq("snap_val", 32'(snap), 32'h123);
    hold(4'd9, 4);
    check_eq("snap_live_cnt", 32'(cnt), 32'h129);
    check_eq("snap_frozen", 32'(snap), 32'h123);
    check_eq("snap_still_valid", 32'(valid), 32'h1);

    // Second request while holding
    latch = 1'b1; tick(2); latch = 1'b0;
    tick(4);
    check_eq("miss_set", 32'(miss), 32'h1);
    check_eq("miss_snap", 32'(snap), 32'h123);
    check_eq("miss_valid", 32'(valid), 32'h1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check_eq("miss_clr", 32'(miss), 32'h0);
    check_eq("miss_clr_valid", 32'(valid), 32'h1);
    check_eq("miss_clr_cnt", 32'(cnt), 32'h009);
    ack = 1'b1; tick(1); ack = 1'b0;
    check_eq("ack_valid", 32'(valid), 32'h0);

    // Asynchronous reset with VALID and OVF set
    latch = 1'b1; tick(2); latch = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      hold(4'd0, 3);
      hold(4'd8, 3);
    end
    check_eq("pre_rst_valid", 32'(valid2), 32'h1);
    check_eq("pre_rst_ovf", 32'(ovf2), 32'h1);
    #2 mr_n = 1'b0;
    #1;
    check_eq("arst_cnt", 32'(cnt), 32'h0);
    check_eq("arst_snap", 32'(snap), 32'h0);
    check_eq("arst_valid", 32'(valid), 32'h0);
    check_eq("arst_valid_w2", 32'(valid2), 32'h0);
    check_eq("arst_ovf_w2", 32'(ovf2), 32'h0);
    check_eq("arst_cnt_w2", 32'(cnt2), 32'h0);
    q_in = 4'd5;
    tick(1);
    mr_n = 1'b1;
    tick(2);
    check_eq("rel_lat_early", 32'(cnt), 32'h000);
    tick(1);
    check_eq("rel_lat_cnt", 32'(cnt), 32'h005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
